// File: rtl/pwm_multi_ch_sched_if.sv
// Duty-update port of the multi-channel PWM scheduler: one channel/duty pair per
// valid/ready transfer.
interface pwm_multi_ch_sched_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 12
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_duty;

    modport master (output cfg_valid, output cfg_ch, output cfg_duty, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_duty, output cfg_ready);
endinterface

// File: rtl/pwm_multi_ch_sched.sv
// Multi-channel PWM scheduler: shared prescaler and period counter, shadowed duty
// updates committed at period wrap. Optional duty ramping with `define PWM_RAMP_EN.
module pwm_multi_ch_sched #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 12,
    parameter int PRESCALE  = 606,
    parameter int PERIOD    = 1000,
    parameter int RAMP_STEP = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  enable,
    pwm_multi_ch_sched_if.slave   cfg,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic                  period_start,
    output logic                  busy
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PER_MAX  = CNT_W'(PERIOD);

    logic [1:0]       state_reg, state_next;
    logic [PS_W-1:0]  presc_cnt_reg;
    logic [CNT_W-1:0] period_cnt_reg;
    logic [CNT_W-1:0] duty_act_reg [NUM_CH];
    logic [CNT_W-1:0] shadow_reg   [NUM_CH];
    logic [CNT_W-1:0] commit_next  [NUM_CH];
    logic [NUM_CH-1:0] pending_reg;
    logic [NUM_CH-1:0] accept;
    logic [CNT_W-1:0] duty_sat;
    logic             running, tick, wrap;

    assign running  = (state_reg != IDLE);
    assign tick     = running && (presc_cnt_reg == PS_LAST);
    assign wrap     = tick && (period_cnt_reg == PER_LAST);
    assign busy     = running;
    assign duty_sat = (cfg.cfg_duty > PER_MAX) ? PER_MAX : cfg.cfg_duty;

    // Out-of-range channel numbers match no entry and are always accepted, then dropped.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                cfg.cfg_ready = !pending_reg[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign accept[gi] = cfg.cfg_valid && (cfg.cfg_ch == CH_W'(gi)) && !pending_reg[gi];
`ifdef PWM_RAMP_EN
            localparam logic [CNT_W-1:0] RAMP_W = CNT_W'(RAMP_STEP);
            logic             up;
            logic [CNT_W-1:0] diff, step;
            assign up   = (shadow_reg[gi] >= duty_act_reg[gi]);
            assign diff = up ? (shadow_reg[gi] - duty_act_reg[gi]) : (duty_act_reg[gi] - shadow_reg[gi]);
            assign step = (diff > RAMP_W) ? RAMP_W : diff;
            assign commit_next[gi] = up ? (duty_act_reg[gi] + step) : (duty_act_reg[gi] - step);
`else
            assign commit_next[gi] = shadow_reg[gi];
`endif
        end
    endgenerate

`ifndef PWM_RAMP_EN
    // Ramp step only matters when ramping is built in.
    logic unused_ramp_step;
    assign unused_ramp_step = ^CNT_W'(RAMP_STEP);
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (!enable) state_next = STOP;
            STOP: begin
                if (enable)    state_next = RUN;
                else if (wrap) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            presc_cnt_reg  <= '0;
            period_cnt_reg <= '0;
            period_start   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            period_start <= ((state_reg == IDLE) && enable) || wrap;
            if (!running) begin
                presc_cnt_reg  <= '0;
                period_cnt_reg <= '0;
            end else begin
                presc_cnt_reg <= tick ? '0 : presc_cnt_reg + 1'b1;
                if (wrap)      period_cnt_reg <= '0;
                else if (tick) period_cnt_reg <= period_cnt_reg + 1'b1;
            end
        end
    end

    // A channel is never both pending and acceptable, so commit and accept cannot collide.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            pwm_out     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act_reg[i] <= '0;
                shadow_reg[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= running && (period_cnt_reg < duty_act_reg[i]);
                if (wrap && pending_reg[i]) begin
                    duty_act_reg[i] <= commit_next[i];
                    pending_reg[i]  <= (commit_next[i] != shadow_reg[i]);
                end else if (accept[i]) begin
                    shadow_reg[i]  <= duty_sat;
                    pending_reg[i] <= 1'b1;
                end
            end
        end
    end
endmodule
